light_dance: RTL
================

LIGHT_DANCE -- requirements
Module: light_dance

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all state updates on rising edge.
REQ-002 SHALL have port arst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port en, input, 1 bit: run enable; low freezes all state.
REQ-004 SHALL have port mode, input, 2 bits: pattern select (00 rotate-left, 01 rotate-right, 10 bounce, 11 fill/drain).
REQ-005 SHALL have port div, input, 4 bits: step period = div+1 enabled cycles.
REQ-006 SHALL have port leds, output, 8 bits: registered LED pattern.
REQ-007 SHALL have port dir, output, 1 bit: registered direction/phase (0 = toward MSB or fill, 1 = toward LSB or drain).
REQ-008 SHALL have port step, output, 1 bit: registered pulse, high exactly one cycle, coincident with each new leds value.

Function
REQ-009 SHALL keep an internal 4-bit prescaler counter cnt and a registered copy mode_q of mode.
REQ-010 SHALL define step_evt = en and (cnt >= div) and (mode == mode_q).
REQ-011 SHALL, on the edge where step_evt holds, set cnt to 0, load leds with the next pattern, and set step to 1.
REQ-012 SHALL, when en=1 and step_evt is false and mode == mode_q, increment cnt and set step to 0.
REQ-013 SHALL, when en=0, hold cnt, leds, dir and mode_q, and set step to 0.
REQ-014 SHALL, when en=1 and mode != mode_q, set mode_q to mode, cnt to 0, dir to 0 and step to 0, and load the seed: 8'h01 for modes 00/01/10, 8'h00 for mode 11. This takes priority over step_evt.
REQ-015 SHALL, in mode 00, rotate left: leds <= {leds[6:0], leds[7]}. 8'h80 wraps to 8'h01; dir stays 0.
REQ-016 SHALL, in mode 01, rotate right: leds <= {leds[0], leds[7:1]}. 8'h01 wraps to 8'h80; dir stays 0.
REQ-017 SHALL, in mode 10, implement a two-state FSM on dir. From LEFT (dir 0), shift left; if leds==8'h80, go to 8'h40 and dir 1. From RIGHT (dir 1), shift right; if leds==8'h01, go to 8'h02 and dir 0.
REQ-018 SHALL, in mode 11, implement a two-state FSM on dir. From FILL (dir 0), leds <= {leds[6:0],1'b1}; if leds==8'hFF, instead go to 8'hFE and dir 1. From DRAIN (dir 1), leds <= {leds[6:0],1'b0}; if leds==8'h00, instead go to 8'h01 and dir 0.
REQ-019 SHALL, when div is lowered below the current cnt, step on the next enabled edge (>= compare) with no lockup.
REQ-020 SHALL, with div=0 and en held high, step every cycle.

Reset
REQ-021 SHALL, while arst=1, force leds=8'h01, dir=0, step=0, cnt=0 and mode_q=2'b00, independent of clk.
REQ-022 SHALL, after arst deasserts with mode != 00, perform the REQ-014 reseed on the first enabled edge.
REQ-023 SHALL abort any pattern mid-sequence when reset is asserted and resume only from the reset values.

Structure
REQ-024 SHALL place the mode encodings, LED width (8), seed constants (8'h01, 8'h00) and dir encodings in shared package light_dance_pkg.
REQ-025 SHALL implement the prescaler (cnt, compare, en gating) as sub-module tick_div, with ports clk, arst, en, clr, div and tick.
REQ-026 SHALL implement all state as edge-triggered flops with asynchronous reset only; no latches, no gated clocks.

Verification
REQ-027 SHALL cover: reset, then mode=00, div=0, en=1 -> leds 01,02,04,...,80,01, and step high every cycle.
REQ-028 SHALL cover: mode=10, div=2 -> leds change every 3rd cycle, sequence 01..80,40,..01,02; dir toggles at 80 and at 01.
REQ-029 SHALL cover: mode=11, div=0 -> leds 00,01,03,...,FF,FE,FC,...,00,01; dir=1 from FE through 00.
REQ-030 SHALL cover: mid-sequence (leds=08), switch mode 00->01 -> next edge leds=01, step=0, cnt=0; the following edge leds=80.
REQ-031 SHALL cover: div=15 with cnt=10, then div set to 3 -> step on the next enabled edge; en=0 for 5 cycles -> leds/cnt frozen, step=0.
REQ-032 SHALL cover: arst pulsed asynchronously between edges while mode=10, leds=20, dir=1 -> leds=01, dir=0, step=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/light_dance_pkg.sv
// Shared encodings and pattern-step logic for the light_dance LED sequencer.
// The top and the prescaler both import this package.
package light_dance_pkg;

  localparam int LED_W = 8;
  localparam int DIV_W = 4;

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'b00,
    MODE_ROTR   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  // DIR_FWD means toward the MSB or filling; DIR_REV means toward the LSB or draining.
  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  localparam logic [LED_W-1:0] SEED_ONE   = 8'h01;
  localparam logic [LED_W-1:0] SEED_EMPTY = 8'h00;
  localparam logic [LED_W-1:0] LED_MSB    = 8'h80;
  localparam logic [LED_W-1:0] LED_FULL   = 8'hFF;

  typedef struct packed {
    logic [LED_W-1:0] leds;
    dir_e             dir;
  } pat_t;

  function automatic logic [LED_W-1:0] seed_for(mode_e m);
    return (m == MODE_FILL) ? SEED_EMPTY : SEED_ONE;
  endfunction

  function automatic pat_t next_pattern(mode_e m, logic [LED_W-1:0] leds, dir_e d);
    pat_t p;
    p.leds = leds;
    p.dir  = d;
    unique case (m)
      MODE_ROTL: p.leds = {leds[LED_W-2:0], leds[LED_W-1]};
      MODE_ROTR: p.leds = {leds[0], leds[LED_W-1:1]};
      MODE_BOUNCE: begin
        if (d == DIR_FWD) begin
          if (leds == LED_MSB) begin
            p.leds = 8'h40;
            p.dir  = DIR_REV;
          end else begin
            p.leds = {leds[LED_W-2:0], 1'b0};
          end
        end else begin
          if (leds == SEED_ONE) begin
            p.leds = 8'h02;
            p.dir  = DIR_FWD;
          end else begin
            p.leds = {1'b0, leds[LED_W-1:1]};
          end
        end
      end
      MODE_FILL: begin
        if (d == DIR_FWD) begin
          if (leds == LED_FULL) begin
            p.leds = 8'hFE;
            p.dir  = DIR_REV;
          end else begin
            p.leds = {leds[LED_W-2:0], 1'b1};
          end
        end else begin
          if (leds == SEED_EMPTY) begin
            p.leds = SEED_ONE;
            p.dir  = DIR_FWD;
          end else begin
            p.leds = {leds[LED_W-2:0], 1'b0};
          end
        end
      end
      default: p = '{leds: leds, dir: d};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Enable-gated step prescaler: tick fires once cnt has reached div, and cnt then restarts.
// A clear (mode change) also restarts the count without ticking.
module tick_div
  import light_dance_pkg::*;
(
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // The >= compare lets a div lowered below cnt fire on the next enabled edge.
  assign tick = en & (cnt_q >= div);

  // NOTE: every combinational output is assigned a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (clr || tick) cnt_d = '0;
      else             cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking stays in always_comb.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/light_dance.sv
// Eight-LED pattern sequencer: rotate, bounce and fill/drain patterns advanced by a prescaler.
// A mode change reseeds the pattern before stepping resumes.
module light_dance
  import light_dance_pkg::*;
(
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [LED_W-1:0] leds,
  output logic             dir,
  output logic             step
);

  mode_e            mode_q, mode_d;
  logic [LED_W-1:0] leds_q, leds_d;
  dir_e             dir_q,  dir_d;
  logic             step_q, step_d;

  logic  tick;
  logic  mode_chg;
  logic  step_evt;
  mode_e mode_in;
  pat_t  nxt;

  assign mode_in  = mode_e'(mode);
  assign mode_chg = (mode_in != mode_q);
  assign step_evt = tick & ~mode_chg;
  assign nxt      = next_pattern(mode_q, leds_q, dir_q);

  tick_div u_tick_div (
    .clk  (clk),
    .arst (arst),
    .en   (en),
    .clr  (mode_chg),
    .div  (div),
    .tick (tick)
  );

  // A mode change wins over a pending step so the new pattern always starts from its seed.
  always_comb begin
    mode_d = mode_q;
    leds_d = leds_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (en) begin
      if (mode_chg) begin
        mode_d = mode_in;
        leds_d = seed_for(mode_in);
        dir_d  = DIR_FWD;
      end else if (step_evt) begin
        leds_d = nxt.leds;
        dir_d  = nxt.dir;
        step_d = 1'b1;
      end
    end
  end

  // NOTE: every flop here is a small control register, so all of them take the async reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mode_q <= MODE_ROTL;
      leds_q <= SEED_ONE;
      dir_q  <= DIR_FWD;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      leds_q <= leds_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign leds = leds_q;
  assign dir  = dir_q;
  assign step = step_q;

endmodule
